// File: rtl/rf_sched_pkg.sv
// Shared types and default sizes for the register-file writeback scheduler.
//   AW, DW, NREG : default register address width, data width, register count
//   wb_req_t     : one write-port request {we, addr, data}
package rf_sched_pkg;
  localparam int AW   = 5;
  localparam int DW   = 32;
  localparam int NREG = 32;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wb_req_t;
endpackage

// File: rtl/rf_scoreboard.sv
// Busy-bit scoreboard of destinations with results still outstanding.
//   clk, rst            : clock, synchronous active-low reset
//   set_en/set_addr     : reserve a destination (takes effect at the edge)
//   clr_en/clr_addr     : release a destination (takes effect at the edge)
//   rd_addr/rd_busy     : NRD combinational read ports
//   busy_vec            : registered busy bits
module rf_scoreboard #(
  parameter int NREG = 32,
  parameter int AW   = 5,
  parameter int NRD  = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    set_en,
  input  logic [AW-1:0]           set_addr,
  input  logic                    clr_en,
  input  logic [AW-1:0]           clr_addr,
  input  logic [NRD-1:0][AW-1:0]  rd_addr,
  output logic [NRD-1:0]          rd_busy,
  output logic [NREG-1:0]         busy_vec
);
  logic [NREG-1:0] busy_q, busy_n;

  // Set is applied after clear so a same-cycle re-reservation survives.
  // Bit 0 is pinned low, so x0 never reads busy on any port.
  always_comb begin
    busy_n = busy_q;
    if (clr_en) busy_n[clr_addr] = 1'b0;
    if (set_en) busy_n[set_addr] = 1'b1;
    busy_n[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst) busy_q <= '0;
    else      busy_q <= busy_n;
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    assign rd_busy[i] = busy_q[rd_addr[i]];
  end

  assign busy_vec = busy_q;
endmodule

// File: rtl/rf_wb_scheduler.sv
// Register-file write-port scheduler.
//   p_*        : in-order pipeline writeback, fixed priority, no back-pressure
//   s_*        : long-latency producer, valid/ready handshake
//   rsv_*      : decode reservation of an S destination
//   dec_*      : decode operands for the RAW/WAW hazard check
//   stall      : hold fetch/decode (hazard or starvation drain)
//   rf_*       : register file write port (combinational)
//   busy_vec   : scoreboard state
module rf_wb_scheduler
  import rf_sched_pkg::*;
#(
  parameter int NREG       = rf_sched_pkg::NREG,
  parameter int AW         = rf_sched_pkg::AW,
  parameter int DW         = rf_sched_pkg::DW,
  parameter int STARVE_MAX = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            p_we,
  input  logic [AW-1:0]   p_addr,
  input  logic [DW-1:0]   p_data,
  input  logic            s_valid,
  input  logic [AW-1:0]   s_addr,
  input  logic [DW-1:0]   s_data,
  output logic            s_ready,
  input  logic            rsv_valid,
  input  logic [AW-1:0]   rsv_addr,
  output logic            rsv_ready,
  input  logic [AW-1:0]   dec_addr_a,
  input  logic [AW-1:0]   dec_addr_b,
  input  logic [AW-1:0]   dec_addr_d,
  input  logic            dec_we,
  output logic            stall,
  output logic            rf_we,
  output logic [AW-1:0]   rf_addr,
  output logic [DW-1:0]   rf_data,
  output logic [NREG-1:0] busy_vec
);
  localparam int CW = $clog2(STARVE_MAX + 1);

  wb_req_t       wb;
  logic          s_grant, s_blocked, hz, force_q;
  logic [CW-1:0] wait_cnt;
  logic [3:0]    rd_busy;

  // Arbiter: P always wins; x0 targets still consume the port but never write.
  always_comb begin
    wb      = '0;
    s_ready = 1'b0;
    if (p_we) begin
      wb.we   = (p_addr != '0);
      wb.addr = p_addr;
      wb.data = p_data;
    end else if (s_valid) begin
      s_ready = 1'b1;
      wb.we   = (s_addr != '0);
      wb.addr = s_addr;
      wb.data = s_data;
    end
    if (!rst) begin
      wb.we   = 1'b0;
      s_ready = 1'b0;
    end
  end

  assign rf_we   = wb.we;
  assign rf_addr = wb.addr;
  assign rf_data = wb.data;

  assign s_grant   = s_valid && s_ready;
  assign s_blocked = s_valid && !s_ready;

  rf_scoreboard #(.NREG(NREG), .AW(AW), .NRD(4)) u_sb (
    .clk      (clk),
    .rst      (rst),
    .set_en   (rsv_ready),
    .set_addr (rsv_addr),
    .clr_en   (s_grant),
    .clr_addr (s_addr),
    .rd_addr  ({rsv_addr, dec_addr_d, dec_addr_b, dec_addr_a}),
    .rd_busy  (rd_busy),
    .busy_vec (busy_vec)
  );

  // Busy bits only drop at the edge, so a register committing this cycle
  // still stalls decode. x0 reads as not busy inside the scoreboard.
  assign hz    = rd_busy[0] || rd_busy[1] || (dec_we && rd_busy[2]);
  assign stall = rst && (hz || force_q);

  // x0 reservations are accepted without marking anything busy.
  assign rsv_ready = rst && rsv_valid && !rd_busy[3] && !stall;

  // Starvation: after STARVE_MAX blocked cycles hold the front end so P
  // drains and a bubble reaches writeback. Force drops once S is granted
  // (or withdraws).
  always_ff @(posedge clk) begin
    if (!rst) begin
      wait_cnt <= '0;
      force_q  <= 1'b0;
    end else begin
      if (!s_blocked)                      wait_cnt <= '0;
      else if (wait_cnt != CW'(STARVE_MAX)) wait_cnt <= wait_cnt + 1'b1;
      force_q <= s_blocked && (force_q || (wait_cnt >= CW'(STARVE_MAX - 1)));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) assert (!s_ready || (s_valid && !p_we));
  end
endmodule

// File: tb/tb_rf_wb_scheduler.sv
module tb_rf_wb_scheduler;
  logic        clk = 1'b0;
  logic        rst;
  logic        p_we, s_valid, s_ready, rsv_valid, rsv_ready, dec_we, stall, rf_we;
  logic [4:0]  p_addr, s_addr, rsv_addr, dec_addr_a, dec_addr_b, dec_addr_d, rf_addr;
  logic [31:0] p_data, s_data, rf_data, busy_vec;

  typedef struct {
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
    logic        srdy;
  } exp_t;
  exp_t expq[$];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rf_wb_scheduler #(.NREG(32), .AW(5), .DW(32), .STARVE_MAX(8)) dut (
    .clk(clk), .rst(rst),
    .p_we(p_we), .p_addr(p_addr), .p_data(p_data),
    .s_valid(s_valid), .s_addr(s_addr), .s_data(s_data), .s_ready(s_ready),
    .rsv_valid(rsv_valid), .rsv_addr(rsv_addr), .rsv_ready(rsv_ready),
    .dec_addr_a(dec_addr_a), .dec_addr_b(dec_addr_b), .dec_addr_d(dec_addr_d),
    .dec_we(dec_we), .stall(stall),
    .rf_we(rf_we), .rf_addr(rf_addr), .rf_data(rf_data), .busy_vec(busy_vec)
  );

  task automatic idle();
    p_we = 0; p_addr = 0; p_data = 0;
    s_valid = 0; s_addr = 0; s_data = 0;
    rsv_valid = 0; rsv_addr = 0;
    dec_addr_a = 0; dec_addr_b = 0; dec_addr_d = 0; dec_we = 0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    idle();
    rst = 0;
    p_we = 1; p_addr = 5; p_data = 32'h1;
    s_valid = 1; s_addr = 7;
    rsv_valid = 1; rsv_addr = 9;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); @(negedge clk);
      checks++;
      if ({rf_we, stall, rsv_ready, s_ready} !== 4'b0000) begin
        errors++;
        $display("FAIL reset_outs c%0d: got we/stall/rsv/srdy=%b want 0000", c, {rf_we, stall, rsv_ready, s_ready});
      end
      checks++;
      if (busy_vec !== 32'h0) begin
        errors++;
        $display("FAIL reset_busy c%0d: got %h want 0", c, busy_vec);
      end
    end
    step();
    idle();
    rst = 1;
  endtask

  task automatic test_p_priority();
    exp_t e;
    p_we = 1; p_addr = 5; p_data = 32'hAAAA0000;
    s_valid = 1; s_addr = 7; s_data = 32'h1234;
    expq.push_back('{1'b1, 5'd5, 32'hAAAA0000, 1'b0});
    @(negedge clk);
    e = expq.pop_front();
    checks++;
    if ({rf_we, rf_addr, rf_data, s_ready} !== {e.we, e.addr, e.data, e.srdy}) begin
      errors++;
      $display("FAIL prio_c1: got we=%b a=%0d d=%h srdy=%b want we=%b a=%0d d=%h srdy=%b",
               rf_we, rf_addr, rf_data, s_ready, e.we, e.addr, e.data, e.srdy);
    end
    step();
    p_we = 0;
    expq.push_back('{1'b1, 5'd7, 32'h1234, 1'b1});
    @(negedge clk);
    e = expq.pop_front();
    checks++;
    if ({rf_we, rf_addr, rf_data, s_ready} !== {e.we, e.addr, e.data, e.srdy}) begin
      errors++;
      $display("FAIL prio_c2: got we=%b a=%0d d=%h srdy=%b want we=%b a=%0d d=%h srdy=%b",
               rf_we, rf_addr, rf_data, s_ready, e.we, e.addr, e.data, e.srdy);
    end
    step();
    idle();
  endtask

  task automatic test_raw();
    exp_t e;
    logic exp_stall;
    rsv_valid = 1; rsv_addr = 9;
    @(negedge clk);
    checks++;
    if (rsv_ready !== 1'b1) begin errors++; $display("FAIL raw_rsv: got %b want 1", rsv_ready); end
    step();
    rsv_valid = 0; dec_addr_a = 9;
    for (int c = 1; c <= 5; c++) begin
      s_valid = 0;
      if (c == 4) begin
        s_valid = 1; s_addr = 9; s_data = 32'h9999;
        expq.push_back('{1'b1, 5'd9, 32'h9999, 1'b1});
      end
      @(negedge clk);
      exp_stall = (c < 5);
      checks++;
      if (stall !== exp_stall) begin
        errors++; $display("FAIL raw_stall c%0d: got %b want %b", c, stall, exp_stall);
      end
      if (c == 1) begin
        checks++;
        if (busy_vec[9] !== 1'b1) begin errors++; $display("FAIL raw_busy_set: got %b want 1", busy_vec[9]); end
      end
      if (c == 4) begin
        e = expq.pop_front();
        checks++;
        if ({rf_we, rf_addr, rf_data, s_ready} !== {e.we, e.addr, e.data, e.srdy}) begin
          errors++;
          $display("FAIL raw_commit: got we=%b a=%0d d=%h srdy=%b want we=%b a=%0d d=%h srdy=%b",
                   rf_we, rf_addr, rf_data, s_ready, e.we, e.addr, e.data, e.srdy);
        end
      end
      if (c == 5) begin
        checks++;
        if (busy_vec[9] !== 1'b0) begin errors++; $display("FAIL raw_busy_clr: got %b want 0", busy_vec[9]); end
      end
      step();
    end
    idle();
  endtask

  task automatic test_waw();
    rsv_valid = 1; rsv_addr = 12;
    step();
    rsv_valid = 0; dec_we = 1; dec_addr_d = 12;
    @(negedge clk);
    checks++;
    if (stall !== 1'b1) begin errors++; $display("FAIL waw_stall: got %b want 1", stall); end
    step();
    dec_we = 0;
    @(negedge clk);
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL waw_nowe: got %b want 0", stall); end
    step();
    dec_addr_b = 12; s_valid = 1; s_addr = 12;
    @(negedge clk);
    checks++;
    if (stall !== 1'b1) begin errors++; $display("FAIL src_b_commit_stall: got %b want 1", stall); end
    step();
    s_valid = 0;
    @(negedge clk);
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL src_b_release: got %b want 0", stall); end
    step();
    idle();
  endtask

  task automatic test_same_cycle();
    rsv_valid = 1; rsv_addr = 3;
    step();
    s_valid = 1; s_addr = 3; s_data = 32'h33;
    @(negedge clk);
    checks++;
    if ({rsv_ready, s_ready} !== 2'b01) begin
      errors++; $display("FAIL same_x3: got rsv/srdy=%b want 01", {rsv_ready, s_ready});
    end
    step();
    idle();
    @(negedge clk);
    checks++;
    if (busy_vec !== 32'h0) begin errors++; $display("FAIL same_clr: got %h want 0", busy_vec); end
    step();
    rsv_valid = 1; rsv_addr = 3;
    step();
    s_valid = 1; s_addr = 3; rsv_addr = 4;
    @(negedge clk);
    checks++;
    if (rsv_ready !== 1'b1) begin errors++; $display("FAIL same_x4_rsv: got %b want 1", rsv_ready); end
    step();
    idle();
    @(negedge clk);
    checks++;
    if (busy_vec !== 32'h0000_0010) begin errors++; $display("FAIL same_x3x4: got %h want 00000010", busy_vec); end
    step();
    s_valid = 1; s_addr = 4;
    step();
    idle();
  endtask

  task automatic test_x0();
    exp_t e;
    s_valid = 1; s_addr = 0; s_data = 32'hDEAD;
    rsv_valid = 1; rsv_addr = 0;
    expq.push_back('{1'b0, 5'd0, 32'hDEAD, 1'b1});
    @(negedge clk);
    e = expq.pop_front();
    checks++;
    if ({rf_we, rf_addr, rf_data, s_ready} !== {e.we, e.addr, e.data, e.srdy}) begin
      errors++;
      $display("FAIL x0_write: got we=%b a=%0d d=%h srdy=%b want we=%b a=%0d d=%h srdy=%b",
               rf_we, rf_addr, rf_data, s_ready, e.we, e.addr, e.data, e.srdy);
    end
    checks++;
    if (rsv_ready !== 1'b1) begin errors++; $display("FAIL x0_rsv: got %b want 1", rsv_ready); end
    step();
    idle();
    @(negedge clk);
    checks++;
    if (busy_vec !== 32'h0) begin errors++; $display("FAIL x0_busy: got %h want 0", busy_vec); end
    step();
  endtask

  task automatic test_starvation();
    exp_t e;
    logic exp_stall;
    p_we = 1; p_addr = 2;
    s_valid = 1; s_addr = 6; s_data = 32'h6666;
    for (int c = 1; c <= 10; c++) begin
      p_data = 32'(c);
      expq.push_back('{1'b1, 5'd2, 32'(c), 1'b0});
      if (c == 10) begin rsv_valid = 1; rsv_addr = 12; end
      @(negedge clk);
      e = expq.pop_front();
      checks++;
      if ({rf_we, rf_addr, rf_data, s_ready} !== {e.we, e.addr, e.data, e.srdy}) begin
        errors++;
        $display("FAIL starve_p c%0d: got we=%b a=%0d d=%h srdy=%b want we=%b a=%0d d=%h srdy=%b",
                 c, rf_we, rf_addr, rf_data, s_ready, e.we, e.addr, e.data, e.srdy);
      end
      exp_stall = (c >= 9);
      checks++;
      if (stall !== exp_stall) begin
        errors++; $display("FAIL starve_stall c%0d: got %b want %b", c, stall, exp_stall);
      end
      if (c == 10) begin
        checks++;
        if (rsv_ready !== 1'b0) begin errors++; $display("FAIL starve_rsv_block: got %b want 0", rsv_ready); end
      end
      step();
    end
    p_we = 0; rsv_valid = 0;
    expq.push_back('{1'b1, 5'd6, 32'h6666, 1'b1});
    @(negedge clk);
    e = expq.pop_front();
    checks++;
    if ({rf_we, rf_addr, rf_data, s_ready} !== {e.we, e.addr, e.data, e.srdy}) begin
      errors++;
      $display("FAIL starve_grant: got we=%b a=%0d d=%h srdy=%b want we=%b a=%0d d=%h srdy=%b",
               rf_we, rf_addr, rf_data, s_ready, e.we, e.addr, e.data, e.srdy);
    end
    checks++;
    if (stall !== 1'b1) begin errors++; $display("FAIL starve_grant_stall: got %b want 1", stall); end
    step();
    idle();
    @(negedge clk);
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL starve_release: got %b want 0", stall); end
    step();
  endtask

  initial begin
    test_reset();
    test_p_priority();
    test_raw();
    test_waw();
    test_same_cycle();
    test_x0();
    test_starvation();
    checks++;
    if (expq.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain: got %0d left want 0", expq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
